// File: rtl/doorlock_ctrl.sv
// Door-lock sequencer: key capture, passcode compare, timed unlock/err/alarm.
// Optional runtime passcode change from OPEN when DOORLOCK_CODE_CHANGE_EN is defined.
module doorlock_ctrl #(
    parameter int              CODE_LEN  = 4,
    parameter logic [31:0]     PASSCODE  = 32'h0000_1234,
    parameter int              MAX_FAIL  = 3,
    parameter int              TW        = 24,
    parameter logic [TW-1:0]   T_OPEN    = 24'd8,
    parameter logic [TW-1:0]   T_FAIL    = 24'd4,
    parameter logic [TW-1:0]   T_LOCKOUT = 24'd16,
    parameter logic [TW-1:0]   T_ENTRY   = 24'd32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       unlock,
    output logic       err,
    output logic       alarm,
    output logic       busy,
    output logic [3:0] digit_cnt,
    output logic [3:0] fail_cnt,
    output logic [2:0] state_o
);
    localparam int CW = CODE_LEN * 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTRY = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_OPEN  = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;
    localparam logic [2:0] S_LOCK  = 3'd5;
`ifdef DOORLOCK_CODE_CHANGE_EN
    localparam logic [2:0] S_SET   = 3'd6;
`endif

    localparam logic [3:0]    LEN4  = 4'(CODE_LEN);
    localparam logic [3:0]    MAXF4 = 4'(MAX_FAIL);
    localparam logic [TW-1:0] TO1   = T_OPEN - 1'b1;
    localparam logic [TW-1:0] TF1   = T_FAIL - 1'b1;
    localparam logic [TW-1:0] TL1   = T_LOCKOUT - 1'b1;
    localparam logic [TW-1:0] TE1   = T_ENTRY - 1'b1;

    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [CW-1:0] r_entry;
    logic [3:0]    r_dcnt;
    logic          r_ovf;
    logic [3:0]    r_fail;
    logic          r_unlock;
    logic          r_err;
    logic          r_alarm;
    logic          r_busy;
    logic [CW-1:0] r_code;

    logic [2:0]    w_nstate;
    logic [TW-1:0] w_ntimer;
    logic [CW-1:0] w_nentry;
    logic [3:0]    w_ndcnt;
    logic          w_novf;
    logic [3:0]    w_nfail;
    logic [CW-1:0] w_ncode;
    logic          w_unlock_d;
    logic          w_err_d;
    logic          w_alarm_d;
    logic          w_busy_d;

    logic          w_digit;
    logic          w_enter;
    logic          w_clear;
    logic          w_match;
    logic [CW-1:0] w_shift;

    assign w_digit = key_valid && (key_code <= 4'h9);
    assign w_enter = key_valid && (key_code == 4'hA);
    assign w_clear = key_valid && (key_code == 4'hB);
    assign w_shift = (r_entry << 4) | CW'(key_code);
    assign w_match = (r_dcnt == LEN4) && !r_ovf && (r_entry == r_code);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_entry  <= '0;
            r_dcnt   <= '0;
            r_ovf    <= 1'b0;
            r_fail   <= '0;
            r_code   <= PASSCODE[CW-1:0];
            r_unlock <= 1'b0;
            r_err    <= 1'b0;
            r_alarm  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_timer  <= w_ntimer;
            r_entry  <= w_nentry;
            r_dcnt   <= w_ndcnt;
            r_ovf    <= w_novf;
            r_fail   <= w_nfail;
            r_code   <= w_ncode;
            r_unlock <= w_unlock_d;
            r_err    <= w_err_d;
            r_alarm  <= w_alarm_d;
            r_busy   <= w_busy_d;
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_ntimer = r_timer;
        w_nentry = r_entry;
        w_ndcnt  = r_dcnt;
        w_novf   = r_ovf;
        w_nfail  = r_fail;
        w_ncode  = r_code;
        case (r_state)
            S_IDLE: begin
                if (w_digit) begin
                    w_nentry = w_shift;
                    w_ndcnt  = 4'd1;
                    w_ntimer = TE1;
                    w_nstate = S_ENTRY;
                end
            end
`ifdef DOORLOCK_CODE_CHANGE_EN
            S_ENTRY, S_SET: begin
`else
            S_ENTRY: begin
`endif
                if (w_digit || w_enter || w_clear)
                    w_ntimer = TE1;
                if (w_digit) begin
                    if (r_dcnt < LEN4) begin
                        w_nentry = w_shift;
                        w_ndcnt  = r_dcnt + 4'd1;
                    end else begin
                        w_novf = 1'b1;
                    end
                end else if (w_enter && r_state == S_ENTRY) begin
                    w_nstate = S_CHECK;
                end else if (w_enter || w_clear || r_timer == '0) begin
`ifdef DOORLOCK_CODE_CHANGE_EN
                    if (w_enter && r_dcnt == LEN4 && !r_ovf)
                        w_ncode = r_entry;
`endif
                    w_nstate = S_IDLE;
                    w_ntimer = '0;
                    w_nentry = '0;
                    w_ndcnt  = '0;
                    w_novf   = 1'b0;
                end else begin
                    w_ntimer = r_timer - 1'b1;
                end
            end
            S_CHECK: begin
                w_nentry = '0;
                w_ndcnt  = '0;
                w_novf   = 1'b0;
                if (w_match) begin
                    w_nfail  = '0;
                    w_ntimer = TO1;
                    w_nstate = S_OPEN;
                end else if (({1'b0, r_fail} + 5'd1) == {1'b0, MAXF4}) begin
                    w_nfail  = MAXF4;
                    w_ntimer = TL1;
                    w_nstate = S_LOCK;
                end else begin
                    w_nfail  = r_fail + 4'd1;
                    w_ntimer = TF1;
                    w_nstate = S_FAIL;
                end
            end
            S_OPEN: begin
                if (r_timer == '0) begin
                    w_nstate = S_IDLE;
                end else begin
                    w_ntimer = r_timer - 1'b1;
`ifdef DOORLOCK_CODE_CHANGE_EN
                    if (w_clear) begin
                        w_ntimer = TE1;
                        w_nstate = S_SET;
                    end
`endif
                end
            end
            S_FAIL: begin
                if (r_timer == '0)
                    w_nstate = S_IDLE;
                else
                    w_ntimer = r_timer - 1'b1;
            end
            S_LOCK: begin
                if (r_timer == '0) begin
                    w_nstate = S_IDLE;
                    w_nfail  = '0;
                end else begin
                    w_ntimer = r_timer - 1'b1;
                end
            end
            default: begin
                w_nstate = S_IDLE;
                w_ntimer = '0;
                w_nentry = '0;
                w_ndcnt  = '0;
                w_novf   = 1'b0;
            end
        endcase
    end

    // outputs are decoded from the next state so they are valid with it
    always_comb begin
        w_unlock_d = (w_nstate == S_OPEN);
        w_err_d    = (w_nstate == S_FAIL);
        w_alarm_d  = (w_nstate == S_LOCK);
        w_busy_d   = (w_nstate == S_CHECK) || (w_nstate == S_OPEN) ||
                     (w_nstate == S_FAIL)  || (w_nstate == S_LOCK);
    end

    assign unlock    = r_unlock;
    assign err       = r_err;
    assign alarm     = r_alarm;
    assign busy      = r_busy;
    assign digit_cnt = r_dcnt;
    assign fail_cnt  = r_fail;
    assign state_o   = r_state;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Scoreboard bench for doorlock_ctrl: expected output pulses are queued by
// the stimulus and checked by an independent pulse monitor.
module tb_doorlock_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       unlock;
    logic       err;
    logic       alarm;
    logic       busy;
    logic [3:0] digit_cnt;
    logic [3:0] fail_cnt;
    logic [2:0] state_o;

    doorlock_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .unlock    (unlock),
        .err       (err),
        .alarm     (alarm),
        .busy      (busy),
        .digit_cnt (digit_cnt),
        .fail_cnt  (fail_cnt),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int len;
        int fail;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // kind: 0 unlock, 1 err, 2 alarm
    task automatic expect_pulse(input int kind, input int len, input int fail);
        exp_t e;
        e.kind = kind;
        e.len  = len;
        e.fail = fail;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    initial begin
        int   cnt[3];
        int   fcap[3];
        logic [2:0] w;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            cnt[k]  = 0;
            fcap[k] = 0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int k = 0; k < 3; k++) cnt[k] = 0;
            end else begin
                w = {alarm, err, unlock};
                for (int k = 0; k < 3; k++) begin
                    if (w[k]) begin
                        if (cnt[k] == 0) fcap[k] = int'(fail_cnt);
                        cnt[k]++;
                    end else if (cnt[k] > 0) begin
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL pulse_unexpected kind=%0d len=%0d",
                                     k, cnt[k]);
                        end else begin
                            e = q.pop_front();
                            if (e.kind != k || e.len != cnt[k] ||
                                e.fail != fcap[k]) begin
                                errors++;
                                $display("FAIL pulse got kind=%0d len=%0d fail=%0d expected kind=%0d len=%0d fail=%0d",
                                         k, cnt[k], fcap[k], e.kind, e.len, e.fail);
                            end
                        end
                        cnt[k] = 0;
                    end
                end
            end
        end
    end

    task automatic press(input logic [3:0] k);
        @(posedge clk);
        #1;
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic seq(input logic [31:0] keys, input int n);
        logic [31:0] v;
        v = keys;
        for (int i = n - 1; i >= 0; i--)
            press(v[4*i +: 4]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (state_o != 3'd0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (state_o != 3'd0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout state=%0d expected=0", name, state_o);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_unlock", unlock, 0);
        chk("rst_err", err, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dcnt", digit_cnt, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_state", state_o, 0);
        rst = 1'b0;

        // correct code, 2-cycle latency, 8-cycle unlock
        expect_pulse(0, 8, 0);
        seq(32'h1234A, 5);
        chk("check_state", state_o, 2);
        chk("check_busy", busy, 1);
        chk("check_unlock", unlock, 0);
        @(posedge clk);
        #1;
        chk("open_unlock", unlock, 1);
        chk("open_state", state_o, 3);
        wait_idle("open");
        chk("open_fail", fail_cnt, 0);

        // three wrong codes -> lockout, keys ignored during it
        expect_pulse(1, 4, 1);
        seq(32'h1235A, 5);
        wait_idle("fail1");
        chk("fail1_cnt", fail_cnt, 1);
        expect_pulse(1, 4, 2);
        seq(32'h1235A, 5);
        wait_idle("fail2");
        expect_pulse(2, 16, 3);
        seq(32'h1235A, 5);
        seq(32'h12A, 3);
        chk("lock_dcnt", digit_cnt, 0);
        chk("lock_busy", busy, 1);
        chk("lock_state", state_o, 5);
        wait_idle("lock");
        chk("lock_exit_fail", fail_cnt, 0);
        chk("lock_exit_dcnt", digit_cnt, 0);

        // overflow entry
        expect_pulse(1, 4, 1);
        seq(32'h12345, 5);
        chk("ovf_dcnt", digit_cnt, 4);
        press(4'hA);
        wait_idle("ovf");

        // short entry
        expect_pulse(1, 4, 2);
        seq(32'h12A, 3);
        wait_idle("short");

        // CLEAR then correct code; prior failures cleared
        expect_pulse(0, 8, 0);
        seq(32'h9B1234A, 7);
        wait_idle("clr_ok");
        chk("clr_ok_fail", fail_cnt, 0);

        // inactivity timeout after 32 idle cycles
        seq(32'h12, 2);
        repeat (31) @(posedge clk);
        #1;
        chk("to_still_entry", state_o, 1);
        @(posedge clk);
        #1;
        chk("to_idle", state_o, 0);
        chk("to_dcnt", digit_cnt, 0);

        // key on idle cycle 31 reloads the timer
        seq(32'h12, 2);
        repeat (29) @(posedge clk);
        press(4'h1);
        chk("reload_dcnt", digit_cnt, 3);
        repeat (3) @(posedge clk);
        #1;
        chk("reload_state", state_o, 1);
        press(4'hB);
        #1;
        chk("reload_clr_state", state_o, 0);

        // reset during OPEN
        seq(32'h1234A, 5);
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_unlock", unlock, 1);
        rst = 1'b1;
        #1;
        chk("arst_unlock", unlock, 0);
        chk("arst_state", state_o, 0);
        chk("arst_fail", fail_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset during FAIL clears fail_cnt
        seq(32'h1A, 2);
        @(posedge clk);
        #2;
        chk("pre_rst_fail", fail_cnt, 1);
        rst = 1'b1;
        #1;
        chk("frst_fail", fail_cnt, 0);
        chk("frst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef DOORLOCK_CODE_CHANGE_EN
        expect_pulse(0, 1, 0);
        seq(32'h1234A, 5);
        press(4'hB);
        chk("set_state", state_o, 6);
        chk("set_busy", busy, 0);
        seq(32'h5678A, 5);
        chk("set_done", state_o, 0);
        expect_pulse(1, 4, 1);
        seq(32'h1234A, 5);
        wait_idle("old_code");
        expect_pulse(0, 8, 0);
        seq(32'h5678A, 5);
        wait_idle("new_code");
        chk("new_code_fail", fail_cnt, 0);
`else
        expect_pulse(0, 8, 0);
        seq(32'h1234A, 5);
        press(4'hB);
        chk("clr_in_open_state", state_o, 3);
        wait_idle("clr_in_open");
        chk("clr_in_open_dcnt", digit_cnt, 0);
`endif

        repeat (5) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/doorlock_ctrl.md
Name: doorlock_ctrl

Overview:
- Central sequencer of the door-lock design: consumes single-cycle key events (debounced and edge-detected upstream), assembles a digit code, compares it against the stored passcode, and drives unlock / error / alarm outputs.
- Enforces timed open window, failure counting, lockout after repeated failures, and entry inactivity timeout.
- Sits between the keypad front end (debounce plus edge detect) and the lock actuator / LED / buzzer drivers.

Parameters:
- CODE_LEN, 4, number of BCD digits in the passcode (1..8).
- PASSCODE, 32'h0000_1234, reset passcode, BCD; low CODE_LEN*4 bits used, digit 0 is the most significant used nibble.
- MAX_FAIL, 3, consecutive failures that trigger lockout (1..15).
- T_OPEN, 24'd8, cycles unlock is held high.
- T_FAIL, 24'd4, cycles err is held high after a wrong code.
- T_LOCKOUT, 24'd16, cycles alarm is held high.
- T_ENTRY, 24'd32, inactivity cycles in ENTRY before abort.
- TW, 24, timer width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- key_valid  in  1  one-cycle pulse; key_code is valid this cycle.
- key_code  in  4  0x0-0x9 digit, 0xA ENTER, 0xB CLEAR, 0xC-0xF ignored.
- unlock  out  1  lock actuator enable.
- err  out  1  wrong-code indication.
- alarm  out  1  lockout indication.
- busy  out  1  high in CHECK/OPEN/FAIL/LOCKOUT; keys are not accepted.
- digit_cnt  out  4  digits captured in the current entry.
- fail_cnt  out  4  consecutive failures.
- state_o  out  3  current state encoding.

Behaviour:
- Reset: state IDLE; unlock=err=alarm=busy=0; digit_cnt=0; fail_cnt=0; entry register=0; overflow flag=0; timer=0; code register=PASSCODE.
- States and encoding: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, FAIL=4, LOCKOUT=5. Codes 6-7 go to IDLE on the next cycle.
- All outputs are registered; they reflect the state entered on the clock edge.
- IDLE:
  - A digit key shifts into the entry register (shift left 4, new digit in the LSB nibble), sets digit_cnt=1, loads timer=T_ENTRY-1, and goes to ENTRY.
  - ENTER, CLEAR, and 0xC-0xF are ignored.
- ENTRY:
  - Any accepted key reloads timer=T_ENTRY-1. With no key, the timer decrements; when it reaches 0 with no key that cycle, go to IDLE and clear the entry register, digit_cnt and overflow flag.
  - Digit with digit_cnt<CODE_LEN: shift in and increment digit_cnt.
  - Digit with digit_cnt==CODE_LEN: set the overflow flag; entry register and digit_cnt are unchanged.
  - CLEAR: go to IDLE and clear the entry register, digit_cnt and overflow flag.
  - ENTER: go to CHECK.
- CHECK (exactly 1 cycle):
  - Match = (digit_cnt==CODE_LEN) AND (overflow flag==0) AND (entry==code).
  - Match: go to OPEN, set fail_cnt=0, load timer=T_OPEN-1.
  - Mismatch with fail_cnt+1==MAX_FAIL: set fail_cnt=MAX_FAIL, go to LOCKOUT, load timer=T_LOCKOUT-1.
  - Otherwise: increment fail_cnt, go to FAIL, load timer=T_FAIL-1.
  - Entry register, digit_cnt and overflow flag are cleared on leaving CHECK.
- OPEN / FAIL / LOCKOUT:
  - The respective output (unlock / err / alarm) is high for exactly T_x cycles; the timer decrements to 0, then the state returns to IDLE.
  - Leaving LOCKOUT clears fail_cnt.
  - key_valid is ignored in these states (except as defined by the optional feature).
- Timing: latency from the ENTER pulse to unlock=1 is 2 cycles (ENTER edge to CHECK, CHECK edge to OPEN).
- Reset mid-operation: immediate return to the reset state; unlock drops asynchronously.
- A key_valid in the same cycle as a timer expiry is dropped.

Optional Feature:
- Macro: DOORLOCK_CODE_CHANGE_EN.
- Defined:
  - In OPEN, CLEAR enters state SET (encoding 6); unlock drops, busy=0.
  - SET captures digits exactly as ENTRY does, with the same inactivity timeout.
  - ENTER with digit_cnt==CODE_LEN and no overflow writes the entry register to the code register, then goes to IDLE.
  - Any other ENTER, CLEAR, or a timeout goes to IDLE with the code unchanged.
  - The code register resets to PASSCODE.
- Undefined: the code register is the constant PASSCODE, encoding 6 behaves as illegal, and CLEAR in OPEN is ignored.

Test Plan:
- Keys 1,2,3,4,ENTER: unlock=1 starting 2 cycles after ENTER and lasting 8 cycles; fail_cnt=0; state returns to IDLE.
- Keys 1,2,3,5,ENTER: err=1 for 4 cycles, fail_cnt=1. Three consecutive wrong codes: alarm=1 for 16 cycles, fail_cnt=3, keys ignored throughout; fail_cnt=0 after exit.
- Keys 1,2,3,4,5,ENTER (overflow): mismatch. Keys 1,2,ENTER (short): mismatch. Keys 9,CLEAR,1,2,3,4,ENTER: unlock.
- Keys 1,2 then 32 idle cycles: return to IDLE with digit_cnt=0. Key 1 arriving at idle cycle 31: timer reloads, state stays ENTRY.
- Assert rst during OPEN: unlock=0 immediately, state=IDLE, fail_cnt=0. Two wrong codes then the correct one: fail_cnt resets to 0.
- With DOORLOCK_CODE_CHANGE_EN: unlock, then CLEAR,5,6,7,8,ENTER. Afterwards 1,2,3,4,ENTER gives err, and 5,6,7,8,ENTER gives unlock.
